// File: rtl/rng_address_sched.sv
// rng_address_sched: round-robin front end that shares one
// rngAddress (which mod count) reduction unit among requesters.
module rng_address_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 65540
) (
  input  logic                      clock,
  input  logic                      nrst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_which,
  input  logic [NUM_REQ*DATA_W-1:0] req_count,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_address,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      unit_nrst,
  output logic                      unit_start,
  output logic [DATA_W-1:0]         unit_which,
  output logic [DATA_W-1:0]         unit_count,
  input  logic [DATA_W-1:0]         unit_address,
  input  logic                      unit_done
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW:0]   NREQ     = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE, CLR, START, WAIT, RESP
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     gnt, gnt_n;
  logic [CW-1:0]     tcnt, tcnt_n;
  logic [DATA_W-1:0] which_n, count_n;
  logic [DATA_W-1:0] addr_n;
  logic              err_n;

  logic [DATA_W-1:0] which_a [NUM_REQ];
  logic [DATA_W-1:0] count_a [NUM_REQ];
  logic              hit;
  logic [PW-1:0]     pick;
  logic [PW:0]       idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      which_a[i] = req_which[i*DATA_W +: DATA_W];
      count_a[i] = req_count[i*DATA_W +: DATA_W];
    end
  end

  // Scan downward so the smallest offset from ptr wins.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[PW-1:0]]) begin
        hit  = 1'b1;
        pick = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    tcnt_n  = tcnt;
    which_n = unit_which;
    count_n = unit_count;
    addr_n  = rsp_address;
    err_n   = rsp_err;
    unique case (state)
      IDLE: begin
        if (hit) begin
          gnt_n   = pick;
          ptr_n   = (pick == PTR_LAST) ? '0 : pick + 1'b1;
          which_n = which_a[pick];
          count_n = count_a[pick];
          if (count_a[pick] == '0) begin
            addr_n  = '0;
            err_n   = 1'b1;
            state_n = RESP;
          end else begin
            state_n = CLR;
          end
        end
      end
      CLR:   state_n = START;
      START: begin
        tcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        tcnt_n = tcnt + 1'b1;
        if (unit_done) begin
          addr_n  = unit_address;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (tcnt == CNT_LAST) begin
          addr_n  = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      tcnt        <= '0;
      ack         <= '0;
      rsp_address <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      unit_nrst   <= 1'b0;
      unit_start  <= 1'b0;
      unit_which  <= '0;
      unit_count  <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      gnt         <= gnt_n;
      tcnt        <= tcnt_n;
      ack         <= (state_n == RESP) ? (NUM_REQ'(1) << gnt_n) : '0;
      rsp_address <= addr_n;
      rsp_err     <= err_n;
      busy        <= (state_n != IDLE);
      unit_nrst   <= (state_n != CLR);
      unit_start  <= (state_n == START);
      unit_which  <= which_n;
      unit_count  <= count_n;
    end
  end

endmodule

// File: tb/tb_rng_address_sched.sv
// tb_rng_address_sched: directed + random jobs against a
// behavioural reduction unit and an arithmetic reference model.
module tb_rng_address_sched;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clock;
  logic          nrst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_which, req_count;
  logic [N-1:0]  ack;
  logic [DW-1:0] rsp_address;
  logic          rsp_err, busy;
  logic          unit_nrst, unit_start;
  logic [DW-1:0] unit_which, unit_count;
  logic [DW-1:0] unit_address;
  logic          unit_done;

  logic [DW-1:0] which_v [N];
  logic [DW-1:0] cnt_v [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_which[g*DW +: DW] = which_v[g];
    assign req_count[g*DW +: DW] = cnt_v[g];
  end

  rng_address_sched #(
    .NUM_REQ(N), .DATA_W(DW), .TIMEOUT(16)
  ) dut (
    .clock(clock), .nrst(nrst),
    .req(req), .req_which(req_which), .req_count(req_count),
    .ack(ack), .rsp_address(rsp_address), .rsp_err(rsp_err),
    .busy(busy), .unit_nrst(unit_nrst), .unit_start(unit_start),
    .unit_which(unit_which), .unit_count(unit_count),
    .unit_address(unit_address), .unit_done(unit_done)
  );

  // Reduction unit: repeated subtraction, sticky done.
  logic [DW-1:0] u_rem, u_cnt, u_addr;
  logic          u_run, u_done, u_stuck;

  always @(posedge clock) begin
    if (!unit_nrst) begin
      u_run  <= 1'b0;
      u_done <= 1'b0;
      u_addr <= '0;
    end else if (unit_start) begin
      u_rem  <= unit_which;
      u_cnt  <= unit_count;
      u_run  <= 1'b1;
      u_done <= 1'b0;
    end else if (u_run && !u_stuck) begin
      if (u_rem >= u_cnt) u_rem <= u_rem - u_cnt;
      else begin
        u_done <= 1'b1;
        u_addr <= u_rem;
        u_run  <= 1'b0;
      end
    end
  end

  assign unit_done    = u_done;
  assign unit_address = u_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int mptr  = 0;
  int n_start, n_low, start_at, low_at;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output int l);
    l = 0;
    n_start = 0; n_low = 0; start_at = 0; low_at = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      l++;
      if (unit_start) begin n_start++; start_at = l; end
      if (!unit_nrst) begin n_low++; low_at = l; end
      if (ack != '0) break;
    end
  endtask

  // Serve njobs from the pending set; keep marks re-requesters.
  task automatic serve(input int njobs, input logic [N-1:0] keep,
                       input string tag);
    int ei, el, q, ea, ee;
    for (int j = 0; j < njobs; j++) begin
      ei = -1;
      for (int k = 0; k < N; k++)
        if (ei < 0 && req[(mptr + k) % N]) ei = (mptr + k) % N;
      if (ei < 0) ei = 0;
      mptr = (ei + 1) % N;
      if (cnt_v[ei] == 0) begin
        el = 1; ea = 0; ee = 1;
      end else begin
        q  = int'(which_v[ei]) / int'(cnt_v[ei]);
        el = q + 5;
        ea = int'(which_v[ei]) % int'(cnt_v[ei]);
        ee = 0;
      end
      if (j > 0) el++;
      wait_ack(40, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_ack"}, 32'(ack), 32'(1 << ei));
      chk({tag, "_addr"}, 32'(rsp_address), 32'(ea));
      chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (!keep[ei]) req[ei] = 1'b0;
    end
    req = '0;
    @(posedge clock); #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int m, q, r, c;
    req = '0;
    u_stuck = 1'b0;
    for (int i = 0; i < N; i++) begin
      which_v[i] = '0; cnt_v[i] = '0;
    end
    nrst = 1'b1;
    #2 nrst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outs", 32'({ack, busy, unit_nrst, unit_start, rsp_err}), 32'd0);
    chk("rst_addr", 32'(rsp_address), 32'd0);
    chk("rst_unit", 32'({unit_which, unit_count}), 32'd0);
    nrst = 1'b1;
    @(posedge clock); #1;
    chk("idle_unrst", 32'(unit_nrst), 32'd1);

    for (int i = 0; i < N; i++) begin
      which_v[i] = 16'd7; cnt_v[i] = 16'd7;
    end
    req = 4'b1111;
    serve(4, 4'b0000, "simul");

    which_v[0] = 16'd5; cnt_v[0] = 16'd2;
    which_v[2] = 16'd5; cnt_v[2] = 16'd2;
    req = 4'b0101;
    serve(4, 4'b0101, "rr");

    which_v[0] = 16'd10; cnt_v[0] = 16'd3;
    req = 4'b0001;
    serve(1, 4'b0000, "single");
    chk("single_nstart", 32'(n_start), 32'd1);
    chk("single_nlow", 32'(n_low), 32'd1);
    chk("single_order", 32'(start_at), 32'(low_at + 1));

    which_v[1] = 16'd5; cnt_v[1] = 16'd0;
    req = 4'b0010;
    serve(1, 4'b0000, "zero");
    chk("zero_nstart", 32'(n_start), 32'd0);

    u_stuck = 1'b1;
    which_v[2] = 16'd3; cnt_v[2] = 16'd1;
    req = 4'b0100;
    wait_ack(40, lat);
    chk("tmo_lat", 32'(lat), 32'd19);
    chk("tmo_ack", 32'(ack), 32'b0100);
    chk("tmo_addr", 32'(rsp_address), 32'd0);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    req = '0;
    mptr = 3;
    @(posedge clock); #1;
    u_stuck = 1'b0;

    for (int rnd = 0; rnd < 8; rnd++) begin
      m = int'($urandom_range(1, 15));
      c = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          cnt_v[i]   = '0;
          which_v[i] = DW'($urandom_range(0, 65535));
        end else begin
          cnt_v[i]   = DW'($urandom_range(1, 4000));
          q          = int'($urandom_range(0, 12));
          r          = int'($urandom_range(0, int'(cnt_v[i]) - 1));
          which_v[i] = DW'(int'(cnt_v[i]) * q + r);
        end
        if (m[i]) c++;
      end
      req = m[N-1:0];
      serve(c, 4'b0000, "rand");
    end

    which_v[0] = 16'd1000; cnt_v[0] = 16'd1;
    req = 4'b0001;
    repeat (6) @(posedge clock);
    #1;
    req  = '0;
    nrst = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({ack, busy, unit_nrst, unit_start, rsp_err}), 32'd0);
    chk("mid_rst_addr", 32'(rsp_address), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("mid_rst_hold", 32'({ack, busy}), 32'd0);
    end
    nrst = 1'b1;
    mptr = 0;
    @(posedge clock); #1;
    which_v[3] = 16'd9; cnt_v[3] = 16'd4;
    req = 4'b1000;
    serve(1, 4'b0000, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rng_address_sched.md
Name: rng_address_sched

Overview:
- Round-robin scheduler that shares one rngAddress reduction unit (rng_address = which mod betterNeighborCount, computed by repeated subtraction) among NUM_REQ requesters.
- Sequences each job on the unit: clear, start, wait for done, return result. The unit's done is sticky, so it is pulsed through reset before every job.
- Guards the unit against divide-by-zero (which would loop forever) and against hang, using a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/result width; must match the unit.
- TIMEOUT, 65540, max cycles in WAIT before abort (more than worst case 65537).

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held until ack.
- req_which  in  NUM_REQ*DATA_W  packed random values; slice i belongs to req[i].
- req_count  in  NUM_REQ*DATA_W  packed betterNeighborCount values; slice i belongs to req[i].
- ack  out  NUM_REQ  one-cycle one-hot completion pulse.
- rsp_address  out  DATA_W  result; valid while any ack bit is high.
- rsp_err  out  1  valid with ack; 1 = zero count or timeout.
- busy  out  1  high in every state except IDLE.
- unit_nrst  out  1  to unit nrst (the unit samples it synchronously).
- unit_start  out  1  to unit start_rng_address.
- unit_which  out  DATA_W  to unit which.
- unit_count  out  DATA_W  to unit betterNeighborCount.
- unit_address  in  DATA_W  from unit rng_address.
- unit_done  in  1  from unit done_rng_address.

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE, ptr=0, all outputs 0 (including unit_nrst=0, which holds the unit in reset), timeout counter 0.
- All outputs are registered.
- IDLE:
  - unit_nrst=1.
  - Grant the lowest index i at or after ptr (cyclic) with req[i]=1.
  - On grant: latch i, which_i and count_i into unit_which/unit_count; set ptr=(i+1) mod NUM_REQ.
  - If count_i==0: go to RESP with rsp_address=0, rsp_err=1; the unit is not started.
  - Otherwise: go to CLR.
- CLR (1 cycle): unit_nrst=0, which clears the unit and its sticky done. Next state START.
- START (1 cycle): unit_nrst=1, unit_start=1. Next state WAIT, with the timeout counter cleared.
- WAIT:
  - unit_start=0; the counter increments each cycle.
  - If unit_done=1: latch unit_address into rsp_address, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_address=0, rsp_err=1, go to RESP.
- RESP (1 cycle): ack[i]=1 for the granted i only; rsp_address/rsp_err hold. Next state IDLE.
- Latency: let t0 be the IDLE cycle in which req[i] is sampled, and q=which/count.
  - Normal job: ack at t0+q+5.
  - Zero count: ack at t0+1.
  - Back-to-back jobs: the next grant is sampled no earlier than ack+1.
- Handshake:
  - Requester holds req and operands stable from assertion until ack.
  - Requester deasserts req in the cycle after ack; req still high in that cycle is a new request.
  - Operands are captured at grant, so later changes do not affect the running job.
  - Dropping req before ack is illegal; the job still completes and ack still pulses.
- Fairness: at most NUM_REQ-1 other jobs are served between a req assertion and its grant.
- Arithmetic: the result is taken unmodified from the unit; no width extension. which<count gives q=0 and address=which.
- Reset mid-job (any state): immediate return to the reset values; the in-flight job is lost with no ack. Requesters re-request after reset.
- Simultaneous requests: resolved only by ptr order; grant occurs in IDLE only.

Test Plan:
- Single job: req[0], which=10, count=3 -> ack=0001 at t0+8; rsp_address=1; rsp_err=0; exactly one unit_start pulse, preceded by one unit_nrst low cycle.
- Zero count: req[1], which=5, count=0 -> ack=0010 at t0+1; rsp_address=0; rsp_err=1; unit_start never asserted.
- Simultaneous: req=1111, all which=7, count=7 -> acks 0001, 0010, 0100, 1000 in order, spaced 7 cycles apart; each rsp_address=0.
- Round-robin: req[0] and req[2] re-request immediately after each ack -> grant order 0, 2, 0, 2; neither requester is served twice in a row.
- Timeout: TIMEOUT=16, unit_done tied low, count=1 -> ack in the 16th WAIT cycle; rsp_err=1; rsp_address=0.
- Async reset in WAIT (which=1000, count=1), nrst low for 2 cycles mid-job -> outputs 0 immediately with no ack; after release, a new job which=9, count=4 gives rsp_address=1 at t0+7.
